// File: rtl/fpall_pkg.sv
// rtl/fpall_pkg.sv - shared types for the multi-precision adder issue scheduler
package fpall_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;

  // [1] = hi lane (dp_x[31:16]), [0] = lo lane; FP32 uses the hi slot only.
  typedef logic [1:0] sched_lane_mask_t;

  localparam sched_lane_mask_t LANE_NONE = 2'b00;
  localparam sched_lane_mask_t LANE_HI   = 2'b10;
  localparam sched_lane_mask_t LANE_BOTH = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  localparam int SCHED_TAG_MAX = 16;

  typedef struct packed {
    fp_fmt_e                  fmt;
    logic [31:0]              r;
    logic [SCHED_TAG_MAX-1:0] tag;
  } sched_res_t;

  function automatic logic [1:0] lane_count(input sched_lane_mask_t m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

endpackage

// File: rtl/fpadd_result_fifo.sv
// rtl/fpadd_result_fifo.sv - result FIFO with an ordered double push and one pop port
module fpadd_result_fifo
  import fpall_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en0,
  input  sched_res_t                 wr_data0,
  input  logic                       wr_en1,
  input  sched_res_t                 wr_data1,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output sched_res_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sched_res_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_1;
  logic          pop;
  logic [1:0]    n_wr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_valid = (count != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
    pop      = rd_en && rd_valid;
    n_wr     = {1'b0, wr_en0} + {1'b0, wr_en1};
    wr_ptr_1 = inc(wr_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count + CW'(n_wr) - CW'(pop);
      if (wr_en0 && wr_en1) begin
        wr_ptr <= inc(wr_ptr_1);
      end else if (wr_en0 || wr_en1) begin
        wr_ptr <= wr_ptr_1;
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
      end
    end
  end

  // Port 0 is always the older entry; port 1 alone packs into the first free slot.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem[wr_ptr] <= wr_data0;
    end
    if (wr_en1) begin
      mem[wr_en0 ? wr_ptr_1 : wr_ptr] <= wr_data1;
    end
  end

endmodule

// File: rtl/fpadd_issue_sched.sv
// rtl/fpadd_issue_sched.sv - pairs BF16 requests into packed adder issues, returns results in order
module fpadd_issue_sched
  import fpall_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int OUT_DEPTH    = 4,
  parameter int PAIR_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output fp_fmt_e          dp_fmt,
  output logic [31:0]      dp_x,
  output logic [31:0]      dp_y,
  input  logic [31:0]      dp_r,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW       = $clog2(OUT_DEPTH + 1);
  localparam int CNT_W    = (PAIR_TIMEOUT < 2) ? 1 : $clog2(PAIR_TIMEOUT);
  localparam int CNT_LAST = (PAIR_TIMEOUT > 0) ? PAIR_TIMEOUT - 1 : 0;

  sched_state_e     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      hold_x, hold_y;
  logic [TAG_W-1:0] hold_tag;
  logic             load_hold;

  logic             iss_valid, iss_valid_n;
  fp_fmt_e          iss_fmt, iss_fmt_n;
  logic [31:0]      iss_x, iss_x_n, iss_y, iss_y_n;
  sched_lane_mask_t iss_mask, iss_mask_n;
  logic [TAG_W-1:0] iss_tag_hi, iss_tag_hi_n, iss_tag_lo, iss_tag_lo_n;

  logic             accept;
  int               resv;
  logic [CW-1:0]    fifo_count;
  logic             fifo_wr0, fifo_wr1, fifo_valid;
  sched_res_t       fifo_d0, fifo_d1, fifo_q;

  // Every accepted request already owns a FIFO slot, so the issue register never stalls.
  always_comb begin
    resv = int'(fifo_count)
         + (iss_valid ? int'(lane_count(iss_mask)) : 0)
         + ((state == HOLD) ? 1 : 0);
    in_ready = rst_n && (resv < OUT_DEPTH) && !((state == HOLD) && (in_fmt == FP32));
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    load_hold    = 1'b0;
    iss_valid_n  = 1'b0;
    iss_fmt_n    = FP32;
    iss_x_n      = '0;
    iss_y_n      = '0;
    iss_mask_n   = LANE_NONE;
    iss_tag_hi_n = '0;
    iss_tag_lo_n = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_fmt == FP32) begin
            iss_valid_n  = 1'b1;
            iss_x_n      = in_x;
            iss_y_n      = in_y;
            iss_mask_n   = LANE_HI;
            iss_tag_hi_n = in_tag;
          end else if (PAIR_TIMEOUT > 0) begin
            state_n   = HOLD;
            cnt_n     = '0;
            load_hold = 1'b1;
          end else begin
            iss_valid_n  = 1'b1;
            iss_fmt_n    = FP16;
            iss_x_n      = {in_x[15:0], 16'h0000};
            iss_y_n      = {in_y[15:0], 16'h0000};
            iss_mask_n   = LANE_HI;
            iss_tag_hi_n = in_tag;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          // Only BF16 can be accepted here; the held request is older, so it takes the hi lane.
          state_n      = IDLE;
          iss_valid_n  = 1'b1;
          iss_fmt_n    = FP16;
          iss_x_n      = {hold_x, in_x[15:0]};
          iss_y_n      = {hold_y, in_y[15:0]};
          iss_mask_n   = LANE_BOTH;
          iss_tag_hi_n = hold_tag;
          iss_tag_lo_n = in_tag;
        end else if ((in_valid && (in_fmt == FP32)) || (cnt == CNT_W'(CNT_LAST))) begin
          state_n      = IDLE;
          iss_valid_n  = 1'b1;
          iss_fmt_n    = FP16;
          iss_x_n      = {hold_x, 16'h0000};
          iss_y_n      = {hold_y, 16'h0000};
          iss_mask_n   = LANE_HI;
          iss_tag_hi_n = hold_tag;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_x     <= '0;
      hold_y     <= '0;
      hold_tag   <= '0;
      iss_valid  <= 1'b0;
      iss_fmt    <= FP32;
      iss_x      <= '0;
      iss_y      <= '0;
      iss_mask   <= LANE_NONE;
      iss_tag_hi <= '0;
      iss_tag_lo <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      if (load_hold) begin
        hold_x   <= in_x[15:0];
        hold_y   <= in_y[15:0];
        hold_tag <= in_tag;
      end
      iss_valid  <= iss_valid_n;
      iss_fmt    <= iss_fmt_n;
      iss_x      <= iss_x_n;
      iss_y      <= iss_y_n;
      iss_mask   <= iss_mask_n;
      iss_tag_hi <= iss_tag_hi_n;
      iss_tag_lo <= iss_tag_lo_n;
    end
  end

  always_comb begin
    dp_fmt = iss_fmt;
    dp_x   = iss_x;
    dp_y   = iss_y;

    fifo_wr0     = iss_valid && iss_mask[1];
    fifo_d0.fmt  = iss_fmt;
    fifo_d0.r    = (iss_fmt == FP32) ? dp_r : {16'h0000, dp_r[31:16]};
    fifo_d0.tag  = SCHED_TAG_MAX'(iss_tag_hi);

    fifo_wr1     = iss_valid && iss_mask[0];
    fifo_d1.fmt  = iss_fmt;
    fifo_d1.r    = {16'h0000, dp_r[15:0]};
    fifo_d1.tag  = SCHED_TAG_MAX'(iss_tag_lo);
  end

  fpadd_result_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en0   (fifo_wr0),
    .wr_data0 (fifo_d0),
    .wr_en1   (fifo_wr1),
    .wr_data1 (fifo_d1),
    .rd_en    (out_ready),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_q),
    .count    (fifo_count)
  );

  always_comb begin
    out_valid = fifo_valid;
    out_fmt   = fifo_q.fmt;
    out_r     = fifo_q.r;
    out_tag   = TAG_W'(fifo_q.tag);
    busy      = (state == HOLD) || iss_valid || (fifo_count != '0);
  end

endmodule

// File: tb/tb_fpadd_issue_sched.sv
// tb/tb_fpadd_issue_sched.sv - self-checking bench for fpadd_issue_sched
module tb_fpadd_issue_sched;
  import fpall_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int PT    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  fp_fmt_e          in_fmt;
  logic [31:0]      in_x, in_y;
  logic [TAG_W-1:0] in_tag;
  fp_fmt_e          dp_fmt;
  logic [31:0]      dp_x, dp_y, dp_r;
  logic             out_valid;
  logic             out_ready;
  fp_fmt_e          out_fmt;
  logic [31:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fpadd_issue_sched #(.TAG_W(TAG_W), .OUT_DEPTH(DEPTH), .PAIR_TIMEOUT(PT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .dp_fmt(dp_fmt), .dp_x(dp_x), .dp_y(dp_y),
    .dp_r(dp_r), .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
    .out_r(out_r), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural float add: exact sum in double precision, truncated back to single.
  function automatic real f32_to_real(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_f32(input real v);
    logic [63:0] d;
    logic [10:0] e;
    if (v == 0.0) return 32'd0;
    d = $realtobits(v);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return real_to_f32(f32_to_real(a) + f32_to_real(b));
  endfunction

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] s;
    s = add32({a, 16'h0000}, {b, 16'h0000});
    return s[31:16];
  endfunction

  always_comb begin
    if (dp_fmt == FP32) dp_r = add32(dp_x, dp_y);
    else dp_r = {add16(dp_x[31:16], dp_y[31:16]), add16(dp_x[15:0], dp_y[15:0])};
  end

  function automatic logic [31:0] model_r(input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y);
    if (f == FP32) return add32(x, y);
    return {16'h0000, add16(x[15:0], y[15:0])};
  endfunction

  typedef struct {
    fp_fmt_e          fmt;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Scoreboard: results must leave in acceptance order with the model's values.
  always @(negedge clk) begin
    res_t e, o;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        o.fmt = out_fmt; o.r = out_r; o.tag = out_tag; o.cyc = cyc;
        obs_q.push_back(o);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected actual=%h/%h expected=none", out_r, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_r !== e.r || out_tag !== e.tag || out_fmt !== e.fmt) begin
            errors++;
            $display("FAIL sb_result actual=%h/%h/%0d expected=%h/%h/%0d",
                     out_r, out_tag, out_fmt, e.r, e.tag, e.fmt);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.fmt = in_fmt; e.r = model_r(in_fmt, in_x, in_y); e.tag = in_tag; e.cyc = cyc;
        exp_q.push_back(e);
      end
      checks++;
      if (exp_q.size() > DEPTH) begin
        errors++;
        $display("FAIL sb_outstanding actual=%0d expected<=%0d", exp_q.size(), DEPTH);
      end
    end
  end

  task automatic send(input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] tag, output int acc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_fmt = f; in_x = x; in_y = y; in_tag = tag;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = cyc; break; end
    end
    chk("send_accepted", 32'(acc >= 0), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    fp_fmt_e          fmt;
    logic [31:0]      x, y;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_dpx;
    logic [31:0]      exp_r;
    int               iss_lat;
    int               out_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acc, t, iss_cyc, n_acc;
    logic [31:0] rv;

    vecs[0] = '{FP32, 32'h3F800000, 32'h40000000, 4'd5, 32'h3F800000, 32'h40400000, 1, 2};
    vecs[1] = '{FP32, 32'h40400000, 32'h3F800000, 4'd6, 32'h40400000, 32'h40800000, 1, 2};
    vecs[2] = '{FP32, 32'hBF800000, 32'h3F800000, 4'd7, 32'hBF800000, 32'h00000000, 1, 2};
    vecs[3] = '{FP16, 32'h00003F80, 32'h00003F80, 4'd1, 32'h3F800000, 32'h00004000, PT+1, PT+2};
    vecs[4] = '{FP16, 32'h00004000, 32'h00004000, 4'd2, 32'h40000000, 32'h00004080, PT+1, PT+2};
    vecs[5] = '{FP16, 32'hFFFF3F80, 32'h12344000, 4'd9, 32'h3F800000, 32'h00004040, PT+1, PT+2};

    rst_n = 1'b0; in_valid = 1'b0; in_fmt = FP32; in_x = '0; in_y = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp_x", dp_x, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Isolated requests: issue/output latency and values.
    foreach (vecs[k]) begin
      obs_q.delete();
      send(vecs[k].fmt, vecs[k].x, vecs[k].y, vecs[k].tag, acc);
      iss_cyc = -1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (iss_cyc < 0 && dp_x != 32'd0) begin
          iss_cyc = cyc;
          chk($sformatf("v%0d_dp_x", k), dp_x, vecs[k].exp_dpx);
          chk($sformatf("v%0d_dp_fmt", k), 32'(dp_fmt), 32'(vecs[k].fmt));
        end
        if (!busy) break;
      end
      chk($sformatf("v%0d_iss_lat", k), 32'(iss_cyc - acc), 32'(vecs[k].iss_lat));
      chk($sformatf("v%0d_nres", k), 32'(obs_q.size()), 32'd1);
      if (obs_q.size() == 1) begin
        chk($sformatf("v%0d_out_lat", k), 32'(obs_q[0].cyc - acc), 32'(vecs[k].out_lat));
        chk($sformatf("v%0d_out_r", k), obs_q[0].r, vecs[k].exp_r);
        chk($sformatf("v%0d_out_tag", k), 32'(obs_q[0].tag), 32'(vecs[k].tag));
      end
    end

    // BF16 pair two cycles apart: one packed issue, hi (older) result first.
    obs_q.delete();
    send(FP16, 32'hDEAD3F80, 32'h00004000, 4'd1, t);
    send(FP16, 32'h00003FC0, 32'hBEEF3FC0, 4'd2, acc);
    chk("pair_gap", 32'(acc - t), 32'd2);
    @(negedge clk);
    chk("pair_dp_fmt", 32'(dp_fmt), 32'(FP16));
    chk("pair_dp_x", dp_x, 32'h3F803FC0);
    chk("pair_dp_y", dp_y, 32'h40003FC0);
    drain();
    chk("pair_nres", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      chk("pair_r0", obs_q[0].r, 32'h00004040);
      chk("pair_tag0", 32'(obs_q[0].tag), 32'd1);
      chk("pair_lat0", 32'(obs_q[0].cyc - t), 32'd4);
      chk("pair_r1", obs_q[1].r, 32'h00004040);
      chk("pair_tag1", 32'(obs_q[1].tag), 32'd2);
      chk("pair_lat1", 32'(obs_q[1].cyc - t), 32'd5);
    end

    // FP32 presented while holding: forced lone flush, FP32 a cycle later.
    obs_q.delete();
    send(FP16, 32'h00003F80, 32'h00003F80, 4'd3, t);
    in_valid = 1'b1; in_fmt = FP32; in_x = 32'h3F800000; in_y = 32'h3F800000; in_tag = 4'd4;
    @(negedge clk);
    chk("flush_blocked", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("flush_dp_x", dp_x, 32'h3F800000);
    chk("flush_dp_fmt", 32'(dp_fmt), 32'(FP16));
    chk("flush_fp32_acc", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    chk("flush_nres", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      chk("flush_tag0", 32'(obs_q[0].tag), 32'd3);
      chk("flush_r0", obs_q[0].r, 32'h00004000);
      chk("flush_tag1", 32'(obs_q[1].tag), 32'd4);
      chk("flush_r1", obs_q[1].r, 32'h40000000);
    end

    // Backpressure: only OUT_DEPTH requests fit until the FIFO drains.
    obs_q.delete();
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (i == 30) begin
        chk("bp_accepted", 32'(n_acc), 32'(DEPTH));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
      in_valid = (n_acc < 6); in_fmt = FP32; in_x = 32'h3F800000;
      in_y = 32'h40000000 + 32'(n_acc << 20); in_tag = TAG_W'(8 + n_acc);
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
    end
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    chk("bp_total", 32'(n_acc), 32'd6);
    chk("bp_nres", 32'(obs_q.size()), 32'd6);
    foreach (obs_q[k]) chk($sformatf("bp_order%0d", k), 32'(obs_q[k].tag), 32'(8 + k));

    // Asynchronous reset while holding with two results queued.
    out_ready = 1'b0;
    send(FP32, 32'h3F800000, 32'h3F800000, 4'd1, acc);
    send(FP32, 32'h40000000, 32'h3F800000, 4'd2, acc);
    send(FP16, 32'h00003F80, 32'h00003F80, 4'd3, acc);
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_r", out_r, 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    chk("arst_dp_x", dp_x, 32'd0);
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    obs_q.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_nres", 32'(obs_q.size()), 32'd0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rv = {1'($urandom), 8'(120 + $urandom_range(14, 0)), 23'($urandom)};
      in_valid  = ($urandom_range(2, 0) != 0);
      in_fmt    = ($urandom_range(1, 0) != 0) ? FP16 : FP32;
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      if (in_fmt == FP32) begin
        in_x = rv;
        in_y = {1'($urandom), 8'(120 + $urandom_range(14, 0)), 23'($urandom)};
      end else begin
        in_x = {16'($urandom), rv[31:16]};
        rv   = {1'($urandom), 8'(120 + $urandom_range(14, 0)), 23'($urandom)};
        in_y = {16'($urandom), rv[31:16]};
      end
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("rand_all_returned", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
